// File: rtl/reg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// reg_bus_arbiter
//
// Shares the internal register bus (16-bit address, 32-bit data, write strobe)
// between NREQ command sources. One requester is granted at a time. Each
// transaction runs a fixed five-state cycle: IDLE -> SETUP -> ACCESS ->
// CAPTURE -> DONE. The requester is acked with a one-cycle pulse in DONE,
// and readback data is presented on rdata at the same time.
//
// Build option:
//   REG_BUS_ARB_FIXED_PRIO_EN  undefined: round-robin selection. The search
//                              starts one above the last grant.
//                              defined:   strict fixed priority, where the
//                              lowest index wins. Requester 0 (host path) can
//                              starve the others.
//
// Parameters:
//   NREQ       number of requesters (2..8)
//   IDXW       width of the grant index (2**IDXW >= NREQ)
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   req        per-requester level request, held until ack
//   req_wr     per-requester 1 = write, 0 = read
//   req_addr   packed per-requester addresses, 16 bits each
//   req_wdata  packed per-requester write data, 32 bits each
//   ack        one-hot, one-cycle transaction acknowledge
//   rdata      readback data captured in CAPTURE, held until next capture
//   reg_addr   register bus address (zero outside SETUP/ACCESS/CAPTURE)
//   reg_wdata  register bus write data (zero outside SETUP/ACCESS/CAPTURE)
//   reg_wr     register bus write strobe, ACCESS only
//   reg_rdata  register bus read data, combinational from addressed register
//   busy       high whenever a transaction is in flight
//   grant_idx  index of the requester being (or last) served
// -----------------------------------------------------------------------------
module reg_bus_arbiter #(
    parameter int NREQ = 2,
    parameter int IDXW = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_wr,
    input  logic [16*NREQ-1:0]     req_addr,
    input  logic [32*NREQ-1:0]     req_wdata,
    output logic [NREQ-1:0]        ack,
    output logic [31:0]            rdata,
    output logic [15:0]            reg_addr,
    output logic [31:0]            reg_wdata,
    output logic                   reg_wr,
    input  logic [31:0]            reg_rdata,
    output logic                   busy,
    output logic [IDXW-1:0]        grant_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            win_vld;
    logic [IDXW-1:0] win_idx;

    logic [15:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            wr_q;

`ifdef REG_BUS_ARB_FIXED_PRIO_EN
    // Lowest index wins. Scanning downward leaves the lowest match as the
    // last assignment.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_vld = 1'b1;
                win_idx = IDXW'(i);
            end
        end
    end
`else
    logic [IDXW-1:0] last_grant;

    // Round robin without a modulo. The first pass only considers indices
    // above last_grant. The second pass wraps to the bottom and includes
    // last_grant itself.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_vld && req[i] && (i > int'(last_grant))) begin
                win_vld = 1'b1;
                win_idx = IDXW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!win_vld && req[i]) begin
                win_vld = 1'b1;
                win_idx = IDXW'(i);
            end
        end
    end

    // Resetting to the top index makes requester 0 the first winner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= IDXW'(NREQ - 1);
        end else if (state == S_IDLE && win_vld) begin
            last_grant <= win_idx;
        end
    end
`endif

    // Control state: FSM, grant index, readback register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            grant_idx <= '0;
            rdata     <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && win_vld) begin
                grant_idx <= win_idx;
            end
            if (state == S_CAPTURE) begin
                rdata <= reg_rdata;
            end
        end
    end

    // Transaction latches. These are only observed while the FSM is
    // outside IDLE, so they need no reset. Later changes on the request
    // inputs cannot disturb a bus cycle in flight.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && win_vld) begin
            addr_q  <= req_addr[16*win_idx +: 16];
            wdata_q <= req_wdata[32*win_idx +: 32];
            wr_q    <= req_wr[win_idx];
        end
    end

    // Next state and bus outputs. These are decoded from state and latches
    // only, so there is no combinational path from req to any output.
    always_comb begin
        state_nxt = state;
        reg_addr  = '0;
        reg_wdata = '0;
        reg_wr    = 1'b0;
        ack       = '0;
        case (state)
            S_IDLE: begin
                if (win_vld) begin
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                reg_addr  = addr_q;
                reg_wdata = wdata_q;
                state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                reg_addr  = addr_q;
                reg_wdata = wdata_q;
                reg_wr    = wr_q;
                state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                reg_addr  = addr_q;
                reg_wdata = wdata_q;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                ack       = NREQ'(1) << grant_idx;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule
